// File: rtl/jtframe_rom_nslots_arb_if.sv
// ---------------------------------------------------------------------------
// jtframe_rom_nslots_arb_if
//
// Read port between an N-slot ROM fetcher and one bank of the jtframe SDRAM
// controller.
//
// Signals:
//   sdram_req   fetcher -> controller  read request, held until sdram_ack
//   sdram_addr  fetcher -> controller  22-bit address in 16-bit words
//   sdram_ack   controller -> fetcher  request accepted
//   data_dst    controller -> fetcher  first 16-bit beat on data_read
//   data_rdy    controller -> fetcher  last beat on data_read, transfer done
//   data_read   controller -> fetcher  16-bit read data
//
// Modports:
//   master  the ROM fetcher side
//   slave   the SDRAM controller side
// ---------------------------------------------------------------------------
interface jtframe_rom_nslots_arb_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_dst;
    logic        data_rdy;
    logic [15:0] data_read;

    modport master (
        output sdram_req,
        output sdram_addr,
        input  sdram_ack,
        input  data_dst,
        input  data_rdy,
        input  data_read
    );

    modport slave (
        input  sdram_req,
        input  sdram_addr,
        output sdram_ack,
        output data_dst,
        output data_rdy,
        output data_read
    );
endinterface

// File: rtl/jtframe_rom_nslots_arb.sv
// ---------------------------------------------------------------------------
// jtframe_rom_nslots_arb
//
// N-slot ROM fetcher for one SDRAM bank. Each of the 2..4 client slots owns
// a tiny word cache; misses are queued as per-slot pending flags and served
// one at a time by a round-robin arbiter that drives a single SDRAM read
// port. A ROM download flushes every cache and blocks new requests.
//
// Parameters:
//   SLOTS    number of client slots, 2..4
//   DW       slot data width, 8, 16 or 32
//   AW       slot address width in DW-sized units, 8..22
//   OFFSETS  per-slot 16-bit-word SDRAM offset, slot k at [k*22 +: 22]
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   downloading    ROM download in progress (flush + block)
//   slot_cs        per-slot chip select
//   slot_addr      packed slot addresses, slot k at [k*AW +: AW]
//   slot_ok        per-slot data valid for the current address
//   slot_dout      packed slot data, slot k at [k*DW +: DW]
//   sdram          master side of the SDRAM read port
//
// Build option:
//   JTFRAME_ROM_CACHE2_EN  when defined each slot holds two cache entries
//                          with 1-bit LRU replacement; otherwise one entry.
// ---------------------------------------------------------------------------
module jtframe_rom_nslots_arb #(
    parameter int                  SLOTS   = 2,
    parameter int                  DW      = 8,
    parameter int                  AW      = 18,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    downloading,
    input  logic [SLOTS-1:0]        slot_cs,
    input  logic [SLOTS*AW-1:0]     slot_addr,
    output logic [SLOTS-1:0]        slot_ok,
    output logic [SLOTS*DW-1:0]     slot_dout,
    jtframe_rom_nslots_arb_if.master sdram
);

`ifdef JTFRAME_ROM_CACHE2_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Arbiter state
    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [21:0]     addr_q, addr_d;
    logic [1:0]      cur_q, cur_d;
    logic [1:0]      last_q, last_d;
    logic [AW-1:0]   tagreg_q, tagreg_d;
    logic [15:0]     lo_q, lo_d;
    logic            drop_q, drop_d;
    logic [SLOTS-1:0] pend_q, pend_d;

    // Cache storage, one row per slot
    logic            valid_q [SLOTS][NE];
    logic            valid_d [SLOTS][NE];
    logic [AW-1:0]   tag_q   [SLOTS][NE];
    logic [AW-1:0]   tag_d   [SLOTS][NE];
    logic [31:0]     data_q  [SLOTS][NE];
    logic [31:0]     data_d  [SLOTS][NE];
`ifdef JTFRAME_ROM_CACHE2_EN
    logic [SLOTS-1:0] lru_q, lru_d;
`endif

    // Per-slot lookup results
    logic [AW-1:0]   addr_k  [SLOTS];
    logic [AW-1:0]   word_k  [SLOTS];
    logic [21:0]     sd_k    [SLOTS];
    logic [31:0]     sel_k   [SLOTS];
    logic            hit_e   [SLOTS][NE];
    logic [SLOTS-1:0] hit;

    // Arbiter choice
    logic            pick_found;
    logic [1:0]      pick;
    logic [31:0]     fill_word;

    // The SDRAM port only sees the registered request; a download in
    // progress masks it at once so a REQ cycle never leaks out.
    assign sdram.sdram_req  = req_q & ~downloading;
    assign sdram.sdram_addr = addr_q;

    // Cache lookup. The tag is the address of the cached 16/32-bit word,
    // so for 8-bit slots both bytes of a word share one entry and addr[0]
    // only picks the byte lane. SDRAM addresses wrap modulo 2^22.
    always_comb begin
        logic any_hit;
        slot_ok   = '0;
        slot_dout = '0;
        hit       = '0;
        any_hit   = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            addr_k[k] = slot_addr[k*AW +: AW];
            word_k[k] = (DW == 8) ? (addr_k[k] >> 1) : addr_k[k];
            sd_k[k]   = ((DW == 32) ? (22'(word_k[k]) << 1) : 22'(word_k[k]))
                        + OFFSETS[k*22 +: 22];
            sel_k[k]  = data_q[k][0];
            any_hit   = 1'b0;
            for (int e = 0; e < NE; e++) begin
                hit_e[k][e] = valid_q[k][e] && (tag_q[k][e] == word_k[k]);
                if (hit_e[k][e]) begin
                    any_hit  = 1'b1;
                    sel_k[k] = data_q[k][e];
                end
            end
            hit[k]     = any_hit & slot_cs[k];
            slot_ok[k] = hit[k];
            if (hit[k]) begin
                if (DW == 8) begin
                    slot_dout[k*DW +: DW] = DW'(addr_k[k][0] ? sel_k[k][15:8]
                                                             : sel_k[k][7:0]);
                end else if (DW == 16) begin
                    slot_dout[k*DW +: DW] = DW'(sel_k[k][15:0]);
                end else begin
                    slot_dout[k*DW +: DW] = DW'(sel_k[k]);
                end
            end
        end
    end

    // Round-robin choice: scan forward from the slot after the last one
    // served, wrapping around, and take the first pending slot found.
    always_comb begin
        pick_found = 1'b0;
        pick       = 2'd0;
        for (int i = 1; i <= SLOTS; i++) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (!pick_found && pend_q[k] &&
                    (k == ((int'(last_q) + i) % SLOTS))) begin
                    pick_found = 1'b1;
                    pick       = 2'(k);
                end
            end
        end
    end

    // Word written into the cache when the last beat arrives.
    always_comb begin
        if (DW == 32) begin
            fill_word = {sdram.data_read, lo_q};
        end else begin
            fill_word = {16'h0000, sdram.data_read};
        end
    end

    // Arbiter next state, pending flags and cache updates. Pending clears
    // when its fill lands even if the slot has moved on to a new address,
    // so the slot simply misses again on the following cycle. A flush wins
    // over everything: it wipes valid/pending and marks an in-flight
    // transfer so its data is thrown away when it drains.
    always_comb begin
        logic vic;
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        cur_d    = cur_q;
        last_d   = last_q;
        tagreg_d = tagreg_q;
        lo_d     = lo_q;
        drop_d   = drop_q;
        pend_d   = pend_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        vic      = 1'b0;
`ifdef JTFRAME_ROM_CACHE2_EN
        lru_d    = lru_q;
`endif

        for (int k = 0; k < SLOTS; k++) begin
            if (slot_cs[k] && !hit[k]) begin
                pend_d[k] = 1'b1;
            end
`ifdef JTFRAME_ROM_CACHE2_EN
            // A hit makes its entry most-recently used.
            if (hit[k]) begin
                lru_d[k] = hit_e[k][0];
            end
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (!downloading && pick_found) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    cur_d   = pick;
                    drop_d  = 1'b0;
                    for (int k = 0; k < SLOTS; k++) begin
                        if (pick == 2'(k)) begin
                            addr_d   = sd_k[k];
                            tagreg_d = word_k[k];
                        end
                    end
                end
            end
            ST_REQ: begin
                if (downloading) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (sdram.sdram_ack) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (downloading) begin
                    drop_d = 1'b1;
                end
                if ((DW == 32) && sdram.data_dst) begin
                    lo_d = sdram.data_read;
                end
                if (sdram.data_rdy) begin
                    state_d = ST_IDLE;
                    if (!drop_q && !downloading) begin
                        last_d = cur_q;
                        for (int k = 0; k < SLOTS; k++) begin
                            if (cur_q == 2'(k)) begin
`ifdef JTFRAME_ROM_CACHE2_EN
                                vic      = lru_q[k];
                                lru_d[k] = ~lru_q[k];
`else
                                vic      = 1'b0;
`endif
                                pend_d[k] = 1'b0;
                                for (int e = 0; e < NE; e++) begin
                                    if (e == int'(vic)) begin
                                        valid_d[k][e] = 1'b1;
                                        tag_d[k][e]   = tagreg_q;
                                        data_d[k][e]  = fill_word;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (downloading) begin
            pend_d = '0;
            for (int k = 0; k < SLOTS; k++) begin
                for (int e = 0; e < NE; e++) begin
                    valid_d[k][e] = 1'b0;
                end
            end
        end
    end

    // State registers. last-served starts at the final slot so that the
    // first scan after reset begins with slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            cur_q    <= '0;
            last_q   <= 2'(SLOTS - 1);
            tagreg_q <= '0;
            lo_q     <= '0;
            drop_q   <= 1'b0;
            pend_q   <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                for (int e = 0; e < NE; e++) begin
                    valid_q[k][e] <= 1'b0;
                    tag_q[k][e]   <= '0;
                    data_q[k][e]  <= '0;
                end
            end
`ifdef JTFRAME_ROM_CACHE2_EN
            lru_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            tagreg_q <= tagreg_d;
            lo_q     <= lo_d;
            drop_q   <= drop_d;
            pend_q   <= pend_d;
            for (int k = 0; k < SLOTS; k++) begin
                for (int e = 0; e < NE; e++) begin
                    valid_q[k][e] <= valid_d[k][e];
                    tag_q[k][e]   <= tag_d[k][e];
                    data_q[k][e]  <= data_d[k][e];
                end
            end
`ifdef JTFRAME_ROM_CACHE2_EN
            lru_q    <= lru_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtframe_rom_nslots_arb.sv
// ---------------------------------------------------------------------------
// tb_jtframe_rom_nslots_arb
//
// Directed bench for jtframe_rom_nslots_arb. Three instances share one
// scripted SDRAM responder (ack/dst/rdy/data); only one instance has any
// chip select active at a time so the others stay idle:
//   u16  SLOTS=4, DW=16, slot0 offset 0x8000  (fill/hit, round robin, flush,
//        cache replacement)
//   u8   SLOTS=2, DW=8                        (byte lanes)
//   u32  SLOTS=2, DW=32                       (two-beat fill)
// ---------------------------------------------------------------------------
module tb_jtframe_rom_nslots_arb;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack   = 1'b0;
    logic        dst   = 1'b0;
    logic        rdy   = 1'b0;
    logic [15:0] rd    = 16'h0000;
    logic        dl16  = 1'b0;

    logic [3:0]  cs16 = '0;
    logic [71:0] a16  = '0;
    logic [3:0]  ok16;
    logic [63:0] dout16;

    logic [1:0]  cs8 = '0;
    logic [35:0] a8  = '0;
    logic [1:0]  ok8;
    logic [15:0] dout8;

    logic [1:0]  cs32 = '0;
    logic [35:0] a32  = '0;
    logic [1:0]  ok32;
    logic [63:0] dout32;

    int total = 0;
    int bad   = 0;

    jtframe_rom_nslots_arb_if if16 ();
    jtframe_rom_nslots_arb_if if8 ();
    jtframe_rom_nslots_arb_if if32 ();

    assign if16.sdram_ack = ack;
    assign if16.data_dst  = dst;
    assign if16.data_rdy  = rdy;
    assign if16.data_read = rd;
    assign if8.sdram_ack  = ack;
    assign if8.data_dst   = dst;
    assign if8.data_rdy   = rdy;
    assign if8.data_read  = rd;
    assign if32.sdram_ack = ack;
    assign if32.data_dst  = dst;
    assign if32.data_rdy  = rdy;
    assign if32.data_read = rd;

    jtframe_rom_nslots_arb #(
        .SLOTS(4), .DW(16), .AW(18), .OFFSETS(88'h8000)
    ) u16 (
        .clk(clk), .rst_n(rst_n), .downloading(dl16),
        .slot_cs(cs16), .slot_addr(a16), .slot_ok(ok16), .slot_dout(dout16),
        .sdram(if16.master)
    );

    jtframe_rom_nslots_arb #(
        .SLOTS(2), .DW(8), .AW(18), .OFFSETS(44'h0)
    ) u8 (
        .clk(clk), .rst_n(rst_n), .downloading(1'b0),
        .slot_cs(cs8), .slot_addr(a8), .slot_ok(ok8), .slot_dout(dout8),
        .sdram(if8.master)
    );

    jtframe_rom_nslots_arb #(
        .SLOTS(2), .DW(32), .AW(18), .OFFSETS(44'h0)
    ) u32 (
        .clk(clk), .rst_n(rst_n), .downloading(1'b0),
        .slot_cs(cs32), .slot_addr(a32), .slot_ok(ok32), .slot_dout(dout32),
        .sdram(if32.master)
    );

    always #5 clk = ~clk;

    // Hard stop in case the script itself ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic req_sel(input int w);
        if (w == 0) return if16.sdram_req;
        if (w == 1) return if8.sdram_req;
        return if32.sdram_req;
    endfunction

    function automatic logic [21:0] addr_sel(input int w);
        if (w == 0) return if16.sdram_addr;
        if (w == 1) return if8.sdram_addr;
        return if32.sdram_addr;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one u16 slot address.
    task automatic applyStimulus(input int k, input logic [17:0] a);
        a16[k*18 +: 18] = a;
    endtask

    // Wait (bounded) for a request on instance w and check its address.
    task automatic waitReq(input int w, input logic [21:0] exp,
                           input string tag);
        int n;
        n = 0;
        #1;
        while (req_sel(w) !== 1'b1 && n < 30) begin
            cyc(1);
            #1;
            n++;
        end
        checkOutput({tag, "_req"}, 32'(req_sel(w)), 32'd1);
        checkOutput({tag, "_addr"}, 32'(addr_sel(w)), 32'(exp));
    endtask

    // Accept the request and return data; DW=32 gets two beats.
    task automatic ackData(input int w, input logic [15:0] lo,
                           input logic [15:0] hi);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        if (w == 2) begin
            dst = 1'b1;
            rd  = lo;
            cyc(1);
            dst = 1'b0;
            rd  = hi;
        end else begin
            rd = lo;
        end
        rdy = 1'b1;
        cyc(1);
        rdy = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        cyc(2);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_req16", 32'(if16.sdram_req), 32'd0);
        checkOutput("rst_addr16", 32'(if16.sdram_addr), 32'd0);
        checkOutput("rst_ok16", 32'(ok16), 32'd0);
        checkOutput("rst_dout16", dout16[31:0], 32'd0);
        checkOutput("rst_req8", 32'(if8.sdram_req), 32'd0);
        checkOutput("rst_dout32", dout32[31:0], 32'd0);

        // ---------------- DW=16 fill then hit ----------------
        cyc(1);
        cs16 = 4'b0001;
        applyStimulus(0, 18'h100);
        #1;
        checkOutput("b_miss_ok", 32'(ok16[0]), 32'd0);
        cyc(1);
        checkOutput("b_req_c1", 32'(if16.sdram_req), 32'd0);
        cyc(1);
        checkOutput("b_req_c2", 32'(if16.sdram_req), 32'd1);
        checkOutput("b_addr", 32'(if16.sdram_addr), 32'h8100);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        #1;
        checkOutput("b_req_drop", 32'(if16.sdram_req), 32'd0);
        rdy = 1'b1;
        rd  = 16'hBEEF;
        cyc(1);
        rdy = 1'b0;
        #1;
        checkOutput("b_ok", 32'(ok16[0]), 32'd1);
        checkOutput("b_dout", 32'(dout16[15:0]), 32'hBEEF);
        cyc(2);
        checkOutput("b_hit_noreq", 32'(if16.sdram_req), 32'd0);
        cs16 = 4'b0000;

        // ---------------- DW=8 byte lanes ----------------
        cs8 = 2'b10;
        a8[18 +: 18] = 18'h201;
        waitReq(1, 22'h100, "d8");
        ackData(1, 16'h12AB, 16'h0000);
        #1;
        checkOutput("d8_ok", 32'(ok8[1]), 32'd1);
        checkOutput("d8_hi", 32'(dout8[15:8]), 32'h12);
        a8[18 +: 18] = 18'h200;
        #1;
        checkOutput("d8_lo_ok", 32'(ok8[1]), 32'd1);
        checkOutput("d8_lo", 32'(dout8[15:8]), 32'hAB);
        cyc(2);
        checkOutput("d8_noreq", 32'(if8.sdram_req), 32'd0);
        cs8 = 2'b00;

        // ---------------- DW=32 two beats ----------------
        cs32 = 2'b01;
        a32[0 +: 18] = 18'h10;
        waitReq(2, 22'h20, "e32");
        ackData(2, 16'h5678, 16'h1234);
        #1;
        checkOutput("e32_ok", 32'(ok32[0]), 32'd1);
        checkOutput("e32_dout", dout32[31:0], 32'h12345678);
        cs32 = 2'b00;

        // ---------------- round robin after reset ----------------
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cs16 = 4'b1111;
        applyStimulus(0, 18'h100);
        applyStimulus(1, 18'h10);
        applyStimulus(2, 18'h20);
        applyStimulus(3, 18'h30);
        #1;
        checkOutput("rr_ok0", 32'(ok16), 32'd0);
        waitReq(0, 22'h8100, "rr0");
        ackData(0, 16'h0A0A, 16'h0000);
        waitReq(0, 22'h10, "rr1");
        ackData(0, 16'h1111, 16'h0000);
        waitReq(0, 22'h20, "rr2");
        ackData(0, 16'h2222, 16'h0000);
        waitReq(0, 22'h30, "rr3");
        applyStimulus(1, 18'h11);
        ackData(0, 16'h3333, 16'h0000);
        waitReq(0, 22'h11, "rr1b");
        ackData(0, 16'h1112, 16'h0000);
        #1;
        checkOutput("rr_okall", 32'(ok16), 32'hF);
        checkOutput("rr_dout2", 32'(dout16[32 +: 16]), 32'h2222);
        checkOutput("rr_dout1", 32'(dout16[16 +: 16]), 32'h1112);

        // ---------------- flush ----------------
        cs16 = 4'b0101;
        applyStimulus(2, 18'h40);
        #1;
        checkOutput("fl_pre_ok", 32'(ok16), 32'h1);
        waitReq(0, 22'h40, "fl");
        ack = 1'b1;
        cyc(1);
        ack  = 1'b0;
        dl16 = 1'b1;
        cyc(1);
        #1;
        checkOutput("fl_ok0", 32'(ok16), 32'd0);
        checkOutput("fl_noreq", 32'(if16.sdram_req), 32'd0);
        cyc(1);
        dl16 = 1'b0;
        rdy  = 1'b1;
        rd   = 16'hDEAD;
        cyc(1);
        rdy = 1'b0;
        #1;
        checkOutput("fl_nocache", 32'(ok16), 32'd0);
        waitReq(0, 22'h40, "fl_re2");
        ackData(0, 16'h2222, 16'h0000);
        waitReq(0, 22'h8100, "fl_re0");
        dl16 = 1'b1;
        #1;
        checkOutput("fl_reqdrop", 32'(if16.sdram_req), 32'd0);
        cyc(1);
        dl16 = 1'b0;
        waitReq(0, 22'h8100, "fl_re0b");
        ackData(0, 16'h0B0B, 16'h0000);
        waitReq(0, 22'h40, "fl_re2b");
        ackData(0, 16'h2323, 16'h0000);
        #1;
        checkOutput("fl_okend", 32'(ok16), 32'h5);
        checkOutput("fl_dout0", 32'(dout16[15:0]), 32'h0B0B);

        // ---------------- replacement ----------------
        cs16 = 4'b1000;
        applyStimulus(3, 18'h50);
        waitReq(0, 22'h50, "g_a");
        ackData(0, 16'hAAAA, 16'h0000);
        #1;
        checkOutput("g_a_dout", 32'(dout16[48 +: 16]), 32'hAAAA);
        applyStimulus(3, 18'h60);
        waitReq(0, 22'h60, "g_b");
        ackData(0, 16'hBBBB, 16'h0000);
        #1;
        checkOutput("g_b_dout", 32'(dout16[48 +: 16]), 32'hBBBB);
        applyStimulus(3, 18'h50);
        #1;
`ifdef JTFRAME_ROM_CACHE2_EN
        checkOutput("g_a_hit", 32'(ok16[3]), 32'd1);
        checkOutput("g_a_hdout", 32'(dout16[48 +: 16]), 32'hAAAA);
        cyc(2);
        checkOutput("g_a_noreq", 32'(if16.sdram_req), 32'd0);
        applyStimulus(3, 18'h70);
        waitReq(0, 22'h70, "g_c");
        ackData(0, 16'hCCCC, 16'h0000);
        applyStimulus(3, 18'h50);
        #1;
        checkOutput("g_a_kept", 32'(ok16[3]), 32'd1);
        applyStimulus(3, 18'h60);
        #1;
        checkOutput("g_b_evict", 32'(ok16[3]), 32'd0);
        waitReq(0, 22'h60, "g_b2");
        ackData(0, 16'hBBBB, 16'h0000);
        #1;
        checkOutput("g_b2_ok", 32'(ok16[3]), 32'd1);
`else
        checkOutput("g_a_miss", 32'(ok16[3]), 32'd0);
        waitReq(0, 22'h50, "g_a2");
        ackData(0, 16'hAAAA, 16'h0000);
        #1;
        checkOutput("g_a2_ok", 32'(ok16[3]), 32'd1);
        checkOutput("g_a2_dout", 32'(dout16[48 +: 16]), 32'hAAAA);
`endif
        cs16 = 4'b0000;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
